// File: rtl/addsub_pipe.sv
// Pipelined WIDTH-bit adder/subtractor: the carry chain is cut into STAGES slices,
// one slice resolved per clock, with a single global stall driven by out_ready.

// One pipeline stage: resolves slice K from the incoming carry and forwards everything else.
module addsub_stage #(
   parameter int WIDTH = 16,
   parameter int W     = 4,
   parameter int K     = 0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             adv,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [WIDTH-1:0] s,
   input  logic             ci,
   output logic [WIDTH-1:0] a_q,
   output logic [WIDTH-1:0] b_q,
   output logic [WIDTH-1:0] s_q,
   output logic             c_q,
   output logic             ov_q
);

   logic [W:0]       t;
   logic [WIDTH-1:0] s_nxt;
   logic             ov_nxt;

   always_comb begin
      t             = {1'b0, a[K*W +: W]} + {1'b0, b[K*W +: W]} + {{W{1'b0}}, ci};
      s_nxt         = s;
      s_nxt[K*W +: W] = t[W-1:0];
      // carry into the msb is a^b^sum at that bit; only meaningful in the top slice
      ov_nxt        = a[WIDTH-1] ^ b[WIDTH-1] ^ s_nxt[WIDTH-1] ^ t[W];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_q  <= '0;
         b_q  <= '0;
         s_q  <= '0;
         c_q  <= 1'b0;
         ov_q <= 1'b0;
      end else if (adv) begin
         a_q  <= a;
         b_q  <= b;
         s_q  <= s_nxt;
         c_q  <= t[W];
         ov_q <= ov_nxt;
      end
   end

endmodule

module addsub_pipe #(
   parameter int WIDTH  = 16,
   parameter int STAGES = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf
);

   localparam int W = WIDTH / STAGES;

   logic                          adv;
   logic [STAGES-1:0]             vld_q;
   logic [STAGES:0]               vld_pipe;
   logic [WIDTH-1:0]              b_eff;
   logic                          c_eff;
   logic [STAGES-1:0][WIDTH-1:0]  a_q, b_q, s_q;
   logic [STAGES-1:0]             c_q, ov_q;
   logic                          unused_ok;

   // subtract folds into add: a + ~b + !cin
   assign b_eff = sub ? ~b : b;
   assign c_eff = sub ? ~cin : cin;

   assign vld_pipe  = {vld_q, in_valid};
   assign out_valid = vld_pipe[STAGES];
   assign adv       = !out_valid || out_ready;
   assign in_ready  = adv;

   // bubbles shift like data; only the valid bit distinguishes them
   always_ff @(posedge clk or posedge rst) begin
      if (rst)      vld_q <= '0;
      else if (adv) vld_q <= vld_pipe[STAGES-1:0];
   end

   for (genvar k = 0; k < STAGES; k++) begin : g_stage
      logic [WIDTH-1:0] ga, gb, gs;
      logic             gc;
      if (k == 0) begin : g_first
         assign ga = a;
         assign gb = b_eff;
         assign gs = '0;
         assign gc = c_eff;
      end else begin : g_next
         assign ga = a_q[k-1];
         assign gb = b_q[k-1];
         assign gs = s_q[k-1];
         assign gc = c_q[k-1];
      end

      addsub_stage #(.WIDTH(WIDTH), .W(W), .K(k)) u_stage (
         .clk  (clk),
         .rst  (rst),
         .adv  (adv),
         .a    (ga),
         .b    (gb),
         .s    (gs),
         .ci   (gc),
         .a_q  (a_q[k]),
         .b_q  (b_q[k]),
         .s_q  (s_q[k]),
         .c_q  (c_q[k]),
         .ov_q (ov_q[k])
      );
   end

   assign sum  = s_q[STAGES-1];
   assign cout = c_q[STAGES-1];
   assign ovf  = ov_q[STAGES-1];

   // last-stage operands and inner-stage overflow bits have no consumer
   assign unused_ok = ^{a_q[STAGES-1], b_q[STAGES-1], ov_q};

endmodule

// File: tb/tb_addsub_pipe.sv
// Scoreboard bench for addsub_pipe: directed and random traffic on a 16/4 instance,
// random sweeps on 8/1 and 32/8 instances, all checked against a signed-arithmetic model.
module tb_addsub_pipe;

   typedef struct {
      longint sum;
      bit     co;
      bit     ov;
   } exp_t;

   int n_cmp = 0;
   int n_err = 0;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // reference: plain unsigned/signed integer arithmetic on w-bit operands
   function automatic exp_t model(input int w, input longint ua, input longint ub,
                                  input bit c, input bit s);
      exp_t   r;
      longint m, half, sa, sb, full, sres;
      m    = longint'(1) << w;
      half = longint'(1) << (w - 1);
      sa   = (ua >= half) ? ua - m : ua;
      sb   = (ub >= half) ? ub - m : ub;
      if (!s) begin
         full = ua + ub + longint'(c);
         r.co = (full >= m);
         sres = sa + sb + longint'(c);
      end else begin
         full = ua - ub - longint'(c);
         r.co = (full >= 0);
         sres = sa - sb - longint'(c);
      end
      r.sum = full & (m - 1);
      r.ov  = (sres < -half) || (sres >= half);
      return r;
   endfunction

   // ---------------- main instance 16 / 4 ----------------
   localparam int MW = 16;
   localparam int MS = 4;

   logic          rst, in_valid, in_ready, cin, sub, out_valid, out_ready, cout, ovf;
   logic [MW-1:0] a, b, sum;
   exp_t          exp_q[$];

   addsub_pipe #(.WIDTH(MW), .STAGES(MS)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .cin(cin), .sub(sub),
      .out_valid(out_valid), .out_ready(out_ready),
      .sum(sum), .cout(cout), .ovf(ovf)
   );

   // issue side: an operation handshaken at the coming edge gets its expectation queued
   always @(negedge clk)
      if (!rst && in_valid && in_ready)
         exp_q.push_back(model(MW, longint'(a), longint'(b), cin, sub));

   always @(negedge clk) begin
      exp_t e;
      if (!rst && out_valid && out_ready) begin
         if (exp_q.size() == 0) check("main spurious out_valid", 64'(1), 64'(0));
         else begin
            e = exp_q.pop_front();
            check("main sum", 64'(sum), 64'(e.sum));
            check("main cout", 64'(cout), 64'(e.co));
            check("main ovf", 64'(ovf), 64'(e.ov));
         end
      end
   end

   // called just after a rising edge; holds the operation until it is accepted
   task automatic drive_op(input logic [MW-1:0] va, input logic [MW-1:0] vb,
                           input logic vc, input logic vs);
      bit acc;
      a = va; b = vb; cin = vc; sub = vs; in_valid = 1'b1;
      acc = 1'b0;
      for (int t = 0; t < 100 && !acc; t++) begin
         @(negedge clk); acc = in_ready;
         @(posedge clk); #1;
      end
      if (!acc) check("main accept timeout", 64'(0), 64'(1));
      in_valid = 1'b0;
   endtask

   // single operation into an empty pipe; counts edges from acceptance to out_valid
   task automatic do_one(input logic [MW-1:0] va, input logic [MW-1:0] vb,
                         input logic vc, input logic vs);
      int lat;
      bit got;
      a = va; b = vb; cin = vc; sub = vs; in_valid = 1'b1;
      @(negedge clk); check("main in_ready idle", 64'(in_ready), 64'(1));
      @(posedge clk); #1 in_valid = 1'b0;
      lat = 1; got = 1'b0;
      for (int k = 0; k < 40 && !got; k++) begin
         @(negedge clk);
         if (out_valid) got = 1'b1;
         else begin @(posedge clk); lat++; end
      end
      check("main latency", got ? 64'(lat) : 64'(-1), 64'(MS));
      @(posedge clk); #1;
   endtask

   // ---------------- sweep instances 8/1 and 32/8 ----------------
   for (genvar g = 0; g < 2; g++) begin : sw
      localparam int SW = (g == 0) ? 8 : 32;
      localparam int SS = (g == 0) ? 1 : 8;

      logic          srst, siv, sir, scin, ssub, sov, sor, sco, sovf;
      logic [SW-1:0] sa, sb, ssum;
      exp_t          q[$];
      bit            done = 1'b0;
      bit            drv_done = 1'b0;

      addsub_pipe #(.WIDTH(SW), .STAGES(SS)) dut_s (
         .clk(clk), .rst(srst), .in_valid(siv), .in_ready(sir),
         .a(sa), .b(sb), .cin(scin), .sub(ssub),
         .out_valid(sov), .out_ready(sor),
         .sum(ssum), .cout(sco), .ovf(sovf)
      );

      always @(negedge clk)
         if (!srst && siv && sir)
            q.push_back(model(SW, longint'(sa), longint'(sb), scin, ssub));

      always @(negedge clk) begin
         exp_t e;
         if (!srst && sov && sor) begin
            if (q.size() == 0) check("sweep spurious out_valid", 64'(1), 64'(0));
            else begin
               e = q.pop_front();
               check("sweep sum", 64'(ssum), 64'(e.sum));
               check("sweep cout", 64'(sco), 64'(e.co));
               check("sweep ovf", 64'(sovf), 64'(e.ov));
            end
         end
      end

      initial begin
         logic [31:0] r;
         int          lat;
         bit          got, acc;
         srst = 1'b1; siv = 1'b0; sor = 1'b1; sa = '0; sb = '0; scin = 1'b0; ssub = 1'b0;
         @(posedge clk); #1 srst = 1'b0;
         r = $urandom; sa = r[SW-1:0]; r = $urandom; sb = r[SW-1:0]; siv = 1'b1;
         @(negedge clk); check("sweep in_ready idle", 64'(sir), 64'(1));
         @(posedge clk); #1 siv = 1'b0;
         lat = 1; got = 1'b0;
         for (int k = 0; k < 40 && !got; k++) begin
            @(negedge clk);
            if (sov) got = 1'b1;
            else begin @(posedge clk); lat++; end
         end
         check("sweep latency", got ? 64'(lat) : 64'(-1), 64'(SS));
         @(posedge clk); #1;
         fork
            begin
               for (int n = 0; n < 1000; n++) begin
                  if ($urandom_range(4) == 0) begin @(posedge clk); #1; end
                  r = $urandom; sa = r[SW-1:0];
                  r = $urandom; sb = r[SW-1:0];
                  scin = 1'($urandom_range(1)); ssub = 1'($urandom_range(1));
                  siv = 1'b1;
                  acc = 1'b0;
                  for (int t = 0; t < 100 && !acc; t++) begin
                     @(negedge clk); acc = sir;
                     @(posedge clk); #1;
                  end
                  if (!acc) check("sweep accept timeout", 64'(0), 64'(1));
                  siv = 1'b0;
               end
               drv_done = 1'b1;
            end
            begin
               while (!drv_done) begin
                  @(posedge clk); #1 sor = ($urandom_range(3) != 0);
               end
               sor = 1'b1;
            end
         join
         for (int t = 0; t < 200 && q.size() != 0; t++) @(posedge clk);
         check("sweep drain", 64'(q.size()), 64'(0));
         done = 1'b1;
      end
   end

   // ---------------- main sequence ----------------
   initial begin
      bit hit;
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
      a = '0; b = '0; cin = 1'b0; sub = 1'b0;
      @(negedge clk);
      check("reset out_valid", 64'(out_valid), 64'(0));
      check("reset in_ready", 64'(in_ready), 64'(1));
      check("reset sum", 64'(sum), 64'(0));
      check("reset cout", 64'(cout), 64'(0));
      check("reset ovf", 64'(ovf), 64'(0));
      @(posedge clk); #1 rst = 1'b0;

      do_one(16'hFFFF, 16'h0001, 1'b0, 1'b0);
      do_one(16'h7FFF, 16'h0001, 1'b0, 1'b0);
      do_one(16'h8000, 16'h0001, 1'b0, 1'b1);
      do_one(16'h0005, 16'h0007, 1'b0, 1'b1);
      do_one(16'h0005, 16'h0007, 1'b1, 1'b1);
      do_one(16'h8000, 16'h8000, 1'b1, 1'b0);

      // back-to-back stream with a 3-cycle stall on the 2nd result
      fork
         begin
            for (int i = 0; i < 8; i++) drive_op(16'(i), 16'(16'h1000 * i), 1'b0, 1'b0);
         end
         begin
            hit = 1'b0;
            for (int t = 0; t < 50 && !hit; t++) begin
               @(posedge clk); #1;
               if (out_valid && sum == 16'h1001) hit = 1'b1;
            end
            check("stream 2nd result seen", 64'(hit), 64'(1));
            out_ready = 1'b0;
            for (int c = 0; c < 3; c++) begin
               @(negedge clk);
               check("stall in_ready", 64'(in_ready), 64'(0));
               check("stall out_valid", 64'(out_valid), 64'(1));
               check("stall sum held", 64'(sum), 64'(16'h1001));
               @(posedge clk); #1;
            end
            out_ready = 1'b1;
            @(negedge clk);
            check("stall release in_ready", 64'(in_ready), 64'(1));
         end
      join
      for (int t = 0; t < 50 && exp_q.size() != 0; t++) @(posedge clk);
      check("stream drain", 64'(exp_q.size()), 64'(0));
      @(posedge clk); #1;

      // random traffic with random backpressure
      hit = 1'b0;
      fork
         begin
            for (int n = 0; n < 200; n++)
               drive_op(16'($urandom), 16'($urandom), 1'($urandom_range(1)),
                        1'($urandom_range(1)));
            hit = 1'b1;
         end
         begin
            while (!hit) begin
               @(posedge clk); #1 out_ready = ($urandom_range(3) != 0);
            end
            out_ready = 1'b1;
         end
      join
      for (int t = 0; t < 50 && exp_q.size() != 0; t++) @(posedge clk);
      check("random drain", 64'(exp_q.size()), 64'(0));
      @(posedge clk); #1;

      // reset with three operations in flight
      for (int i = 0; i < 3; i++) drive_op(16'($urandom), 16'($urandom), 1'b0, 1'b0);
      in_valid = 1'b0;
      rst = 1'b1;
      #1;
      check("midreset out_valid", 64'(out_valid), 64'(0));
      check("midreset sum", 64'(sum), 64'(0));
      check("midreset cout", 64'(cout), 64'(0));
      check("midreset ovf", 64'(ovf), 64'(0));
      check("midreset in_ready", 64'(in_ready), 64'(1));
      exp_q.delete();
      @(posedge clk); #1 rst = 1'b0;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         check("post-reset no stale", 64'(out_valid), 64'(0));
      end

      for (int t = 0; t < 20000 && !(sw[0].done && sw[1].done); t++) @(posedge clk);
      check("sweeps finished", 64'(sw[0].done && sw[1].done), 64'(1));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
